// File: rtl/ctrl_rw_sched.sv
// CAS command queue feeding a read/write data-phase scheduler.
// Each entry counts down its latency; the head launches a burst when due.
package ctrl_rw_sched_pkg;
  localparam logic [2:0] RD  = 3'd0;
  localparam logic [2:0] RDA = 3'd1;
  localparam logic [2:0] WR  = 3'd2;
  localparam logic [2:0] WRA = 3'd3;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} ph_e;
endpackage

module ctrl_rw_sched
  import ctrl_rw_sched_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LAT_W   = 6,
  parameter int BL8_CYC = 4,
  parameter int BC4_CYC = 2
) (
  input  logic                       CK_t,
  input  logic                       reset_n,
  input  logic                       cas_rdy,
  input  logic [2:0]                 cas_req,
  input  logic                       bc4,
  input  logic [LAT_W-1:0]           CL,
  input  logic [LAT_W-1:0]           CWL,
  input  logic [LAT_W-1:0]           AL,
  input  logic [LAT_W-1:0]           RD_PRE,
  input  logic [LAT_W-1:0]           WR_PRE,
  output logic                       rd_rdy,
  output logic                       wr_rdy,
  output logic                       rda_rdy,
  output logic                       wra_rdy,
  output logic                       rd_active,
  output logic                       wr_active,
  output logic                       rw_done,
  output logic                       data_idle,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       overflow_err,
  output logic                       timing_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [LAT_W+1:0] MAXL = {2'b00, {LAT_W{1'b1}}};

  typedef struct packed {
    logic             wr;
    logic             ap;
    logic             bc4;
    logic [LAT_W-1:0] cnt;
  } ent_t;

  ent_t            r_q [DEPTH];
  logic [PW-1:0]   r_hd;
  logic [PW-1:0]   r_tl;
  logic [CW-1:0]   r_cnt;
  ph_e             r_state;
  ph_e             w_nxt;
  logic [7:0]      r_left;
  logic [7:0]      w_left_nxt;
  logic            r_rd_rdy;
  logic            r_wr_rdy;
  logic            r_rda_rdy;
  logic            r_wra_rdy;
  logic            r_ovf;
  logic            r_terr;

  logic            w_is_rd;
  logic            w_ap;
  logic            w_bad;
  logic [LAT_W+1:0] w_sum;
  logic [LAT_W-1:0] w_lat;
  ent_t            w_new;
  ent_t            w_hd;
  logic            w_empty;
  logic            w_full;
  logic            w_busy;
  logic            w_last;
  logic            w_due;
  logic            w_pop;
  logic            w_push;

  always_comb begin
    w_is_rd = (cas_req == RD) || (cas_req == RDA);
    w_ap    = (cas_req == RDA) || (cas_req == WRA);
    w_bad   = cas_req > WRA;
    w_sum   = w_is_rd ?
              ({2'b00, CL} + {2'b00, AL} + {2'b00, RD_PRE}) :
              ({2'b00, CWL} + {2'b00, AL} + {2'b00, WR_PRE});
    w_lat   = (w_sum > MAXL) ? {LAT_W{1'b1}} : w_sum[LAT_W-1:0];
    if (w_lat == '0) w_lat = LAT_W'(1);
    w_new.wr  = !w_is_rd;
    w_new.ap  = w_ap;
    w_new.bc4 = bc4;
    w_new.cnt = w_lat - LAT_W'(1);
  end

  assign w_hd    = r_q[r_hd];
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_busy  = (r_state != S_IDLE);
  assign w_last  = w_busy && (r_left == 8'd1);
  assign w_due   = !w_empty && (w_hd.cnt == '0);
  // A due head launches only from idle or from the final burst cycle
  assign w_pop   = w_due && (!w_busy || w_last);
  assign w_push  = cas_rdy && (!w_full || w_pop);

  always_comb begin
    w_nxt      = r_state;
    w_left_nxt = r_left;
    if (w_pop) begin
      w_nxt      = w_hd.wr ? S_WR : S_RD;
      w_left_nxt = w_hd.bc4 ? 8'(BC4_CYC) : 8'(BL8_CYC);
    end else if (w_busy) begin
      w_left_nxt = r_left - 8'd1;
      if (w_last) w_nxt = S_IDLE;
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_left    <= '0;
      r_rd_rdy  <= 1'b0;
      r_wr_rdy  <= 1'b0;
      r_rda_rdy <= 1'b0;
      r_wra_rdy <= 1'b0;
      r_ovf     <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_left    <= w_left_nxt;
      r_rd_rdy  <= w_pop && !w_hd.wr;
      r_wr_rdy  <= w_pop && w_hd.wr;
      r_rda_rdy <= w_pop && !w_hd.wr && w_hd.ap;
      r_wra_rdy <= w_pop && w_hd.wr && w_hd.ap;
      if (cas_rdy && w_full && !w_pop) r_ovf <= 1'b1;
      if ((w_due && !w_pop) || (cas_rdy && w_bad)) r_terr <= 1'b1;
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_hd  <= '0;
      r_tl  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q[i].cnt != '0) r_q[i].cnt <= r_q[i].cnt - LAT_W'(1);
      end
      if (w_push) begin
        r_q[r_tl] <= w_new;
        r_tl      <= r_tl + PW'(1);
      end
      if (w_pop) r_hd <= r_hd + PW'(1);
      if (w_push && !w_pop) r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign rd_rdy       = r_rd_rdy;
  assign wr_rdy       = r_wr_rdy;
  assign rda_rdy      = r_rda_rdy;
  assign wra_rdy      = r_wra_rdy;
  assign rd_active    = (r_state == S_RD);
  assign wr_active    = (r_state == S_WR);
  assign data_idle    = !w_busy;
  assign rw_done      = w_empty && !w_busy;
  assign occupancy    = r_cnt;
  assign full         = w_full;
  assign overflow_err = r_ovf;
  assign timing_err   = r_terr;

endmodule

// File: tb/tb_ctrl_rw_sched.sv
// Randomized bench for ctrl_rw_sched against a schedule-level model.
// The model derives burst start times from due times and prior burst ends.
module tb_ctrl_rw_sched;
  import ctrl_rw_sched_pkg::*;

  localparam int DEPTH = 8;
  localparam int LAT_W = 6;
  localparam int BL8   = 4;
  localparam int BC4   = 2;
  localparam int NEVER = 1 << 30;

  logic             CK_t = 1'b0;
  logic             reset_n = 1'b0;
  logic             cas_rdy = 1'b0;
  logic [2:0]       cas_req = 3'd0;
  logic             bc4 = 1'b0;
  logic [LAT_W-1:0] CL = '0;
  logic [LAT_W-1:0] CWL = '0;
  logic [LAT_W-1:0] AL = '0;
  logic [LAT_W-1:0] RD_PRE = '0;
  logic [LAT_W-1:0] WR_PRE = '0;
  logic rd_rdy, wr_rdy, rda_rdy, wra_rdy;
  logic rd_active, wr_active, rw_done, data_idle;
  logic [$clog2(DEPTH):0] occupancy;
  logic full, overflow_err, timing_err;

  ctrl_rw_sched #(
    .DEPTH(DEPTH), .LAT_W(LAT_W), .BL8_CYC(BL8), .BC4_CYC(BC4)
  ) dut (
    .CK_t(CK_t), .reset_n(reset_n), .cas_rdy(cas_rdy),
    .cas_req(cas_req), .bc4(bc4),
    .CL(CL), .CWL(CWL), .AL(AL), .RD_PRE(RD_PRE), .WR_PRE(WR_PRE),
    .rd_rdy(rd_rdy), .wr_rdy(wr_rdy),
    .rda_rdy(rda_rdy), .wra_rdy(wra_rdy),
    .rd_active(rd_active), .wr_active(wr_active),
    .rw_done(rw_done), .data_idle(data_idle),
    .occupancy(occupancy), .full(full),
    .overflow_err(overflow_err), .timing_err(timing_err)
  );

  always #5 CK_t = ~CK_t;

  typedef struct {
    int enq;
    int st;
    int ln;
    bit wr;
    bit ap;
  } ph_t;

  ph_t q[$];
  int  cyc = 0;
  int  last_end = 0;
  int  last_st = 0;
  int  terr_from = NEVER;
  int  ovf_from = NEVER;
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
  endtask

  function automatic int lat(input bit rd);
    int s;
    s = rd ? int'(CL) + int'(AL) + int'(RD_PRE)
           : int'(CWL) + int'(AL) + int'(WR_PRE);
    if (s > (1 << LAT_W) - 1) s = (1 << LAT_W) - 1;
    if (s == 0) s = 1;
    return s;
  endfunction

  task automatic model_cmd(input logic [2:0] req, input bit b);
    int pend = 0;
    bit pop = 0;
    bit rd;
    int d, st, ee;
    ph_t p;
    if (req > WRA && cyc < terr_from) terr_from = cyc;
    foreach (q[i]) begin
      if (q[i].enq < cyc && q[i].st >= cyc) pend++;
      if (q[i].st == cyc) pop = 1;
    end
    if (pend == DEPTH && !pop) begin
      if (cyc < ovf_from) ovf_from = cyc;
      return;
    end
    rd = (req == RD) || (req == RDA);
    d  = cyc + lat(rd);
    st = (d > last_end) ? d : last_end;
    // a late entry is flagged once it is both head and due
    ee = (d > last_st + 1) ? d : last_st + 1;
    if (ee < st && ee < terr_from) terr_from = ee;
    p.enq = cyc;
    p.st  = st;
    p.ln  = b ? BC4 : BL8;
    p.wr  = !rd;
    p.ap  = (req == RDA) || (req == WRA);
    last_st  = st;
    last_end = st + p.ln;
    q.push_back(p);
  endtask

  task automatic check_all();
    int occ = 0;
    int rp = 0, wp = 0, rap = 0, wap = 0, ra = 0, wa = 0;
    while (q.size() > 0 && q[0].st + q[0].ln < cyc) q.delete(0);
    foreach (q[i]) begin
      if (q[i].enq <= cyc && q[i].st > cyc) occ++;
      if (q[i].st == cyc) begin
        if (q[i].wr) begin wp = 1; wap = int'(q[i].ap); end
        else begin rp = 1; rap = int'(q[i].ap); end
      end
      if (q[i].st <= cyc && cyc < q[i].st + q[i].ln) begin
        if (q[i].wr) wa = 1;
        else ra = 1;
      end
    end
    chk("rd_rdy", int'(rd_rdy), rp);
    chk("wr_rdy", int'(wr_rdy), wp);
    chk("rda_rdy", int'(rda_rdy), rap);
    chk("wra_rdy", int'(wra_rdy), wap);
    chk("rd_active", int'(rd_active), ra);
    chk("wr_active", int'(wr_active), wa);
    chk("data_idle", int'(data_idle), int'(ra == 0 && wa == 0));
    chk("rw_done", int'(rw_done), int'(occ == 0 && ra == 0 && wa == 0));
    chk("occupancy", int'(occupancy), occ);
    chk("full", int'(full), int'(occ == DEPTH));
    chk("overflow_err", int'(overflow_err), int'(cyc >= ovf_from));
    chk("timing_err", int'(timing_err), int'(cyc >= terr_from));
  endtask

  task automatic step(input bit v, input logic [2:0] req, input bit b);
    cas_rdy = v;
    cas_req = req;
    bc4 = b;
    @(posedge CK_t);
    cyc++;
    if (v) model_cmd(req, b);
    @(negedge CK_t);
    cas_rdy = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, RD, 1'b0);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rd_rdy"}, int'(rd_rdy), 0);
    chk({tag, "_wr_rdy"}, int'(wr_rdy), 0);
    chk({tag, "_rda_rdy"}, int'(rda_rdy), 0);
    chk({tag, "_wra_rdy"}, int'(wra_rdy), 0);
    chk({tag, "_rd_active"}, int'(rd_active), 0);
    chk({tag, "_wr_active"}, int'(wr_active), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_ovf"}, int'(overflow_err), 0);
    chk({tag, "_terr"}, int'(timing_err), 0);
    chk({tag, "_occ"}, int'(occupancy), 0);
    chk({tag, "_rw_done"}, int'(rw_done), 1);
    chk({tag, "_data_idle"}, int'(data_idle), 1);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk_rst("rst_async");
    q.delete();
    @(posedge CK_t);
    cyc++;
    @(negedge CK_t);
    chk_rst("rst_hold");
    reset_n = 1'b1;
    last_end  = cyc;
    last_st   = cyc;
    terr_from = NEVER;
    ovf_from  = NEVER;
  endtask

  task automatic set_lat(input int cl, input int cwl, input int al,
                         input int rp, input int wp);
    CL = LAT_W'(cl);
    CWL = LAT_W'(cwl);
    AL = LAT_W'(al);
    RD_PRE = LAT_W'(rp);
    WR_PRE = LAT_W'(wp);
  endtask

  initial begin
    int pulses;
    int p, n, r;
    logic [2:0] req;
    #1;
    chk_rst("rst_init");
    repeat (2) @(posedge CK_t);
    @(negedge CK_t);
    reset_n = 1'b1;

    // single read, L = 12
    set_lat(11, 9, 0, 1, 1);
    idle(3);
    step(1'b1, RD, 1'b0);
    idle(20);

    // chopped auto-precharge write, L = 12
    set_lat(11, 9, 2, 1, 1);
    step(1'b1, WRA, 1'b1);
    idle(18);

    // seamless back-to-back reads
    set_lat(11, 9, 0, 1, 1);
    step(1'b1, RD, 1'b0);
    idle(3);
    step(1'b1, RD, 1'b0);
    idle(20);
    chk("b2b_terr", int'(timing_err), 0);

    // reads too close together
    step(1'b1, RD, 1'b0);
    idle(1);
    step(1'b1, RD, 1'b0);
    idle(22);
    chk("late_terr", int'(timing_err), 1);

    // overflow with nine writes at L = 20
    do_reset();
    set_lat(11, 19, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1'b1, WR, 1'b0);
    chk("full8", int'(full), 1);
    step(1'b1, WR, 1'b0);
    chk("ovf9", int'(overflow_err), 1);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, RD, 1'b0);
      if (wr_rdy) pulses++;
    end
    chk("ovf_phases", pulses, 8);

    // reset in the second cycle of a read burst
    do_reset();
    set_lat(11, 9, 0, 1, 1);
    step(1'b1, RD, 1'b0);
    n = 0;
    while (!rd_rdy && n < 40) begin
      step(1'b0, RD, 1'b0);
      n++;
    end
    chk("burst_seen", int'(rd_rdy), 1);
    step(1'b0, RD, 1'b0);
    do_reset();
    idle(16);
    chk("post_rst_done", int'(rw_done), 1);

    // randomized segments, latencies fixed per drained segment
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      if ($urandom_range(0, 9) == 0)
        set_lat($urandom_range(30, 63), $urandom_range(30, 63),
                $urandom_range(0, 63), $urandom_range(0, 3),
                $urandom_range(0, 3));
      else
        set_lat($urandom_range(0, 12), $urandom_range(0, 12),
                $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 2));
      p = $urandom_range(10, 70);
      n = $urandom_range(10, 50);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 15);
        req = (r < 14) ? 3'(r % 4) : 3'(4 + r % 4);
        step($urandom_range(0, 99) < p, req, 1'($urandom_range(0, 1)));
      end
      n = 0;
      while (!rw_done && n < 400) begin
        step(1'b0, RD, 1'b0);
        n++;
      end
      chk("drain", int'(rw_done), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
